// File: rtl/pipeline_exmem_register_pkg.sv
// Shared pipeline definitions: MemtoReg encodings, WB/M bundle bit positions
// and default widths used by the ID/EX, EX/MEM and MEM/WB registers.
package pipeline_exmem_register_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam int DEF_CNT_WIDTH      = 16;

   localparam int WB_WIDTH        = 3;
   localparam int WB_REGWRITE_BIT = 2;
   localparam int WB_MEMTOREG_HI  = 1;
   localparam int WB_MEMTOREG_LO  = 0;

   localparam int M_WIDTH        = 2;
   localparam int M_MEMREAD_BIT  = 1;
   localparam int M_MEMWRITE_BIT = 0;

   typedef enum logic [1:0] {
      MEMTOREG_ALU  = 2'd0,
      MEMTOREG_MEM  = 2'd1,
      MEMTOREG_PC4  = 2'd2,
      MEMTOREG_RSVD = 2'd3
   } memtoreg_e;

endpackage

// File: rtl/pipeline_exmem_register_if.sv
// EX/MEM register bus: execute-stage inputs and memory-stage outputs.
// bubble_count exists only when EXMEM_BUBBLE_COUNT_EN is defined.
interface pipeline_exmem_register_if
   import pipeline_exmem_register_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
`ifdef EXMEM_BUBBLE_COUNT_EN
   ,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH
`endif
);
   logic                      enable;
   logic                      flush;
   logic                      valid_in;
   logic [WB_WIDTH-1:0]       DataInputWB_EXMEM;
   logic [M_WIDTH-1:0]        DataInputM_EXMEM;
   logic [DATA_WIDTH-1:0]     ALUResult_in;
   logic [DATA_WIDTH-1:0]     WriteData_in;
   logic [DATA_WIDTH-1:0]     PCPlus4_in;
   logic [REG_ADDR_WIDTH-1:0] WriteReg_in;

   logic [WB_WIDTH-1:0]       DataOutputWB_EXMEM;
   logic                      MemRead_out;
   logic                      MemWrite_out;
   logic [DATA_WIDTH-1:0]     ALUResult_out;
   logic [DATA_WIDTH-1:0]     WriteData_out;
   logic [DATA_WIDTH-1:0]     PCPlus4_out;
   logic [REG_ADDR_WIDTH-1:0] WriteReg_out;
   logic                      valid_out;
   logic                      FwdRegWrite;
   logic [REG_ADDR_WIDTH-1:0] FwdWriteReg;
`ifdef EXMEM_BUBBLE_COUNT_EN
   logic [CNT_WIDTH-1:0]      bubble_count;
`endif

   modport master (
      output enable, flush, valid_in, DataInputWB_EXMEM, DataInputM_EXMEM,
             ALUResult_in, WriteData_in, PCPlus4_in, WriteReg_in,
      input  DataOutputWB_EXMEM, MemRead_out, MemWrite_out, ALUResult_out,
             WriteData_out, PCPlus4_out, WriteReg_out, valid_out,
             FwdRegWrite, FwdWriteReg
`ifdef EXMEM_BUBBLE_COUNT_EN
             , bubble_count
`endif
   );

   modport slave (
      input  enable, flush, valid_in, DataInputWB_EXMEM, DataInputM_EXMEM,
             ALUResult_in, WriteData_in, PCPlus4_in, WriteReg_in,
      output DataOutputWB_EXMEM, MemRead_out, MemWrite_out, ALUResult_out,
             WriteData_out, PCPlus4_out, WriteReg_out, valid_out,
             FwdRegWrite, FwdWriteReg
`ifdef EXMEM_BUBBLE_COUNT_EN
             , bubble_count
`endif
   );

endinterface

// File: rtl/pipeline_exmem_register_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_exmem_register.sv
// EX/MEM pipeline register with stall, flush and valid tracking.
// Optional bubble counter enabled by EXMEM_BUBBLE_COUNT_EN.
module pipeline_exmem_register
   import pipeline_exmem_register_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
`ifdef EXMEM_BUBBLE_COUNT_EN
   ,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   pipeline_exmem_register_if.slave      bus
);
   logic [WB_WIDTH-1:0]       r_wb;
   logic [M_WIDTH-1:0]        r_m;
   logic [DATA_WIDTH-1:0]     r_alu;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [DATA_WIDTH-1:0]     r_pc4;
   logic [REG_ADDR_WIDTH-1:0] r_wreg;
   logic                      r_valid;

   logic                      w_regwrite;
   memtoreg_e                 w_memtoreg;
   logic [M_WIDTH-1:0]        w_m;

   // Writes to $0 and writes from invalid slots never reach the register file.
   assign w_regwrite = bus.DataInputWB_EXMEM[WB_REGWRITE_BIT] & bus.valid_in &
                       (bus.WriteReg_in != '0);
   assign w_memtoreg = memtoreg_e'(bus.DataInputWB_EXMEM[WB_MEMTOREG_HI:WB_MEMTOREG_LO]);
   assign w_m        = bus.DataInputM_EXMEM & {M_WIDTH{bus.valid_in}};

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         r_wb    <= '0;
         r_m     <= '0;
         r_alu   <= '0;
         r_wdata <= '0;
         r_pc4   <= '0;
         r_wreg  <= '0;
         r_valid <= 1'b0;
      end else if (bus.enable) begin
         r_wb    <= {w_regwrite, w_memtoreg};
         r_m     <= w_m;
         r_alu   <= bus.ALUResult_in;
         r_wdata <= bus.WriteData_in;
         r_pc4   <= bus.PCPlus4_in;
         r_wreg  <= bus.WriteReg_in;
         r_valid <= bus.valid_in;
      end
   end

   assign bus.DataOutputWB_EXMEM = r_wb;
   assign bus.MemRead_out        = r_m[M_MEMREAD_BIT];
   assign bus.MemWrite_out       = r_m[M_MEMWRITE_BIT];
   assign bus.ALUResult_out      = r_alu;
   assign bus.WriteData_out      = r_wdata;
   assign bus.PCPlus4_out        = r_pc4;
   assign bus.WriteReg_out       = r_wreg;
   assign bus.valid_out          = r_valid;
   assign bus.FwdRegWrite        = r_wb[WB_REGWRITE_BIT] & r_valid;
   assign bus.FwdWriteReg        = r_wreg;

`ifdef EXMEM_BUBBLE_COUNT_EN
   logic w_bubble_inc;

   // A bubble is any loaded invalid entry; reset priority lives in the counter.
   assign w_bubble_inc = bus.flush | (bus.enable & ~bus.valid_in);

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_bubble_cnt (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_inc   (w_bubble_inc),
      .o_count (bus.bubble_count)
   );
`endif

endmodule

// File: tb/tb_pipeline_exmem_register.sv
// Self-checking bench for pipeline_exmem_register: directed plan steps plus
// randomized traffic against a field-level reference model.
module tb_pipeline_exmem_register;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef EXMEM_BUBBLE_COUNT_EN
   localparam int CW = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

`ifdef EXMEM_BUBBLE_COUNT_EN
   pipeline_exmem_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
   pipeline_exmem_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
`else
   pipeline_exmem_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();
   pipeline_exmem_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
`endif

   // Reference model state: what each output must show after the next edge.
   logic [2:0]    e_wb;
   logic          e_mr, e_mw, e_valid;
   logic [DW-1:0] e_alu, e_wd, e_pc4;
   logic [AW-1:0] e_wreg;
   int            e_cnt;

   task automatic model_edge();
      if (reset || bus.flush) begin
         e_wb = 3'b000; e_mr = 1'b0; e_mw = 1'b0; e_valid = 1'b0;
         e_alu = '0; e_wd = '0; e_pc4 = '0; e_wreg = '0;
`ifdef EXMEM_BUBBLE_COUNT_EN
         if (reset) e_cnt = 0;
         else if (e_cnt < (1 << CW) - 1) e_cnt = e_cnt + 1;
`endif
      end else if (bus.enable) begin
         e_valid = bus.valid_in;
         e_wb[2] = bus.DataInputWB_EXMEM[2] && bus.valid_in && (bus.WriteReg_in != 0);
         e_wb[1:0] = bus.DataInputWB_EXMEM[1:0];
         e_mr = bus.DataInputM_EXMEM[1] && bus.valid_in;
         e_mw = bus.DataInputM_EXMEM[0] && bus.valid_in;
         e_alu = bus.ALUResult_in; e_wd = bus.WriteData_in; e_pc4 = bus.PCPlus4_in;
         e_wreg = bus.WriteReg_in;
`ifdef EXMEM_BUBBLE_COUNT_EN
         if (!bus.valid_in && e_cnt < (1 << CW) - 1) e_cnt = e_cnt + 1;
`endif
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".wb"}, 128'(bus.DataOutputWB_EXMEM), 128'(e_wb));
      chk({ph, ".mem"}, 128'({bus.MemRead_out, bus.MemWrite_out}), 128'({e_mr, e_mw}));
      chk({ph, ".data"}, 128'({bus.ALUResult_out, bus.WriteData_out, bus.PCPlus4_out}),
          128'({e_alu, e_wd, e_pc4}));
      chk({ph, ".wreg"}, 128'(bus.WriteReg_out), 128'(e_wreg));
      chk({ph, ".valid"}, 128'(bus.valid_out), 128'(e_valid));
      chk({ph, ".fwd"}, 128'({bus.FwdRegWrite, bus.FwdWriteReg}),
          128'({e_wb[2] & e_valid, e_wreg}));
`ifdef EXMEM_BUBBLE_COUNT_EN
      chk({ph, ".cnt"}, 128'(bus.bubble_count), 128'(e_cnt));
`endif
   endtask

   // Inputs were driven 1 time unit after the previous edge; outputs must not react
   // until the next edge, then must match the model.
   task automatic tick(input bit pre);
      #1;
      if (pre) check_all("hold_between_edges");
      model_edge();
      @(posedge clk);
      #1;
      check_all("post_edge");
   endtask

   task automatic drive(input logic rst, input logic en, input logic fl, input logic v,
                        input logic [2:0] wb, input logic [1:0] m, input logic [DW-1:0] alu,
                        input logic [DW-1:0] wd, input logic [DW-1:0] pc4, input logic [AW-1:0] wr);
      reset = rst; bus.enable = en; bus.flush = fl; bus.valid_in = v;
      bus.DataInputWB_EXMEM = wb; bus.DataInputM_EXMEM = m;
      bus.ALUResult_in = alu; bus.WriteData_in = wd; bus.PCPlus4_in = pc4; bus.WriteReg_in = wr;
   endtask

   task automatic drive_rand(input logic rst, input logic en, input logic fl, input logic v);
      logic [AW-1:0] wr;
      wr = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      drive(rst, en, fl, v, 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, wr);
   endtask

   initial begin
      e_cnt = 0;
      // Reset for two cycles with arbitrary inputs
      drive_rand(1'b1, 1'b1, 1'b0, 1'b1);
      tick(1'b0);
      drive_rand(1'b1, 1'b1, 1'b1, 1'b1);
      tick(1'b1);
      chk("reset_valid_zero", 128'(bus.valid_out), 128'(0));

      // Capture
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 2'b10, 32'h40, 32'h1234, 32'h104, 5'd8);
      tick(1'b1);
      chk("cap_wb", 128'(bus.DataOutputWB_EXMEM), 128'(3'b101));
      chk("cap_memread", 128'(bus.MemRead_out), 128'(1));
      chk("cap_alu", 128'(bus.ALUResult_out), 128'(32'h40));
      chk("cap_fwd", 128'({bus.FwdRegWrite, bus.FwdWriteReg}), 128'({1'b1, 5'd8}));

      // $0 suppression
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 2'b00, 32'h55, 32'h66, 32'h77, 5'd0);
      tick(1'b1);
      chk("zero_wb", 128'(bus.DataOutputWB_EXMEM), 128'(3'b000));
      chk("zero_fwd", 128'(bus.FwdRegWrite), 128'(0));

      // Stall then release: A captured, B presented during 3 stalled cycles
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 2'b01, 32'hA0, 32'hA1, 32'hA2, 5'd10);
      tick(1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 2'b10, 32'hB0 + 32'(i), 32'hB1, 32'hB2, 5'd11);
         tick(1'b1);
         chk("stall_hold_alu", 128'(bus.ALUResult_out), 128'(32'hA0));
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 2'b10, 32'hB0, 32'hB1, 32'hB2, 5'd11);
      tick(1'b1);
      chk("release_alu", 128'(bus.ALUResult_out), 128'(32'hB0));
      chk("release_wreg", 128'(bus.WriteReg_out), 128'(5'd11));

      // Flush during stall
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 2'b11, 32'hC0, 32'hC1, 32'hC2, 5'd12);
      tick(1'b1);
      chk("flush_valid", 128'(bus.valid_out), 128'(0));
`ifdef EXMEM_BUBBLE_COUNT_EN
      chk("flush_cnt", 128'(bus.bubble_count), 128'(1));

      // Saturation after a fresh reset: reset+flush does not count
      drive_rand(1'b1, 1'b1, 1'b1, 1'b1);
      tick(1'b1);
      chk("rst_flush_cnt", 128'(bus.bubble_count), 128'(0));
      for (int i = 0; i < 5; i++) begin
         drive_rand(1'b0, 1'($urandom), 1'b1, 1'b1);
         tick(1'b1);
      end
      chk("sat_cnt", 128'(bus.bubble_count), 128'(3));
      drive_rand(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1);
      chk("sat_hold_cnt", 128'(bus.bubble_count), 128'(3));
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive_rand(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
         tick(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
